// File: rtl/output_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : output_result_fifo
// Purpose  : DEPTH-entry first-word-fall-through FIFO for ALU results with a
//            valid/ready output, occupancy, full/empty and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module output_result_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              load,
    input  logic              clear,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_overflow;

    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;

    // Pointers carry one extra bit so equal indices can mean either full or empty.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_count == c_depth);
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = load & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_one;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_one;
            if (load & ~w_push)
                r_overflow <= 1'b1;
        end
    end

    // Storage holds no reset; stale entries are never visible because out_data is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push & ~clear)
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= in_data;
    end

    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign out_valid = ~w_empty;
    assign count     = w_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_result_fifo
// Purpose  : Scoreboard bench for output_result_fifo (queue reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_result_fifo;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              reset_n;
    logic [WIDTH-1:0]  in_data;
    logic              load;
    logic              clear;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ovf;

    output_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .load      (load),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
        check({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        check({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
        if (exp_q.size() == 0)
            check({tag, "_zero"}, 32'(out_data), 32'h0);
        else
            check({tag, "_head"}, 32'(out_data), 32'(exp_q[0]));
    endtask

    // Called at posedge+1: drives inputs, predicts the edge, advances, then checks.
    task automatic step(input string tag, input logic ld, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
        bit do_pop;
        bit do_push;
        load      = ld;
        in_data   = d;
        out_ready = rdy;
        clear     = clr;
        #1;
        do_pop  = (exp_q.size() != 0) && rdy;
        do_push = ld && ((exp_q.size() < DEPTH) || do_pop);
        if (do_pop)
            check({tag, "_popdata"}, 32'(out_data), 32'(exp_q[0]));
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (do_pop)
                void'(exp_q.pop_front());
            if (do_push)
                exp_q.push_back(d);
            if (ld && !do_push)
                exp_ovf = 1'b1;
        end
        check_state(tag);
    endtask

    initial begin
        exp_ovf   = 1'b0;
        reset_n   = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("rst");
        reset_n = 1'b1;

        // Basic push with backpressure, then consume it.
        step("push_a5", 1'b1, 16'h00A5, 1'b0, 1'b0);
        check("a5_data", 32'(out_data), 32'h00A5);
        step("pop_a5", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 4; i++)
            step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        check("full_flag", 32'(full), 32'h1);
        step("ovf_push", 1'b1, 16'h0005, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_cnt", 32'(count), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(out_data), 32'(i));
            step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(empty), 32'h1);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Clear together with load drops the load and clears overflow.
        for (int i = 0; i < 3; i++)
            step("pre_clr", 1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0);
        step("clear", 1'b1, 16'h00EE, 1'b1, 1'b1);
        check("clr_cnt", 32'(count), 32'h0);
        check("clr_ovf", 32'(overflow), 32'h0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++)
            step("refill", 1'b1, 16'(i), 1'b0, 1'b0);
        step("full_pp", 1'b1, 16'h0009, 1'b1, 1'b0);
        check("fpp_cnt", 32'(count), 32'h4);
        check("fpp_ovf", 32'(overflow), 32'h0);
        check("fpp_head", 32'(out_data), 32'h0002);
        for (int i = 0; i < 4; i++)
            step("fpp_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Pointer wrap with one entry in flight.
        for (int i = 0; i < 10; i++) begin
            step("wrap", 1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            check("wrap_le1", 32'(count <= 1), 32'h1);
        end
        step("wrap_last", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: head must hold steady.
        step("bp_a", 1'b1, 16'h0A0A, 1'b0, 1'b0);
        step("bp_b", 1'b1, 16'h0B0B, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1'b0, 16'h0000, 1'b0, 1'b0);
            check("bp_data", 32'(out_data), 32'h0A0A);
        end

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check_state("async_rst");
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, 16'h0C0C, 1'b0, 1'b0);
        check("post_rst_d", 32'(out_data), 32'h0C0C);
        check("post_rst_ptr", 32'(dut.r_wr_ptr), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_result_fifo.md
Name: output_result_fifo

Overview:
- Parametrised successor to the single-entry ALU output register.
- Buffers up to DEPTH ALU results of WIDTH bits in arrival order and presents them downstream through a valid/ready handshake.
- Sits between the ALU result bus and the display/host consumer, so a slow consumer no longer loses results.
- Provides occupancy, full/empty, a sticky overflow flag and a synchronous clear.

Parameters:
- WIDTH, 16, data width of each stored result.
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  ALU result to store
- load  input  1  push request; in_data is sampled at the same rising edge
- clear  input  1  synchronous flush of contents and overflow flag
- out_data  output  WIDTH  oldest stored result (first-word-fall-through)
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  consumer accepts out_data this cycle
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky flag: a load was dropped

Behaviour:
- Reset: reset_n low asynchronously sets the following, independent of clk:
  - read and write pointers = 0, count = 0
  - empty = 1, full = 0, out_valid = 0, overflow = 0
  - out_data = 0
  - Storage array contents need not be reset.
- Pointers are ADDR_W+1 bits wide.
  - The low ADDR_W bits index the storage; the MSB distinguishes full from empty.
  - Both pointers wrap modulo 2*DEPTH.
- Handshake and decode:
  - pop = out_valid & out_ready.
  - push_ok = load & (~full | pop).
- Latency:
  - A push at edge N is visible at the output after edge N: out_valid = 1 and out_data = in_data, provided the FIFO was empty.
  - There is no extra cycle of latency.
- out_data:
  - Driven from storage at the read pointer whenever out_valid = 1.
  - Forced to 0 when empty.
  - out_data and out_valid must not change while out_valid = 1 and out_ready = 0.
- out_valid = ~empty. out_valid does not depend combinationally on out_ready.
- count, full and empty are registered or derived only from registered pointers. They update at the edge where a push or pop occurs.
- Simultaneous push and pop:
  - Not empty and not full: both are performed; count is unchanged.
  - Full: the pop frees the slot and the push is accepted; count stays DEPTH; overflow is not set.
  - Empty: no pop is possible; the push is accepted; count becomes 1.
- Overflow:
  - load while full and no pop: in_data is discarded and the contents are unchanged.
  - overflow is set to 1 and stays high until clear or reset.
- Pop while empty: impossible, since out_valid = 0. out_ready is ignored.
- clear:
  - At the edge: pointers = 0, count = 0, overflow = 0.
  - Has priority over load and pop in the same cycle; that load is dropped and does not set overflow.
- Reset asserted mid-operation: all state is lost immediately. The first push after reset_n deasserts lands in entry 0.
- count arithmetic: count(next) = count + push_ok − pop, unsigned ADDR_W+1 bits. It can never exceed DEPTH or go below 0.

Test Plan:
- Reset and basic push: hold reset_n = 0, then release; check empty = 1, count = 0, out_data = 0. Push 16'h00A5 with out_ready = 0; the next cycle must show out_valid = 1, out_data = 16'h00A5, count = 1.
- Fill to full and order: push 16'h0001..16'h0004 with out_ready = 0, giving full = 1 and count = 4. Push 16'h0005; check overflow = 1 and count = 4. Drain with out_ready = 1; the outputs must be 1, 2, 3, 4 in order, then empty = 1, with overflow still 1.
- Full with simultaneous push and pop: from full (1..4), assert load = 1 with 16'h0009 and out_ready = 1. Check count stays 4, overflow stays 0, and the drain order is 2, 3, 4, 9.
- Wrap-around: perform 10 push/pop pairs of 16'h0100+i with continuous out_ready = 1. Every pushed value must emerge in order, and count must never exceed 1.
- Backpressure stability: with 2 entries stored and out_ready = 0 held for 5 cycles, out_data and out_valid must stay constant.
- Clear and reset mid-operation: with 3 entries and overflow = 1, assert clear together with load. The next cycle must show count = 0, overflow = 0, empty = 1. Refill 2 entries, pulse reset_n low between edges, and check that all outputs clear immediately without waiting for a clk edge.
